// File: rtl/hypot_pkg.sv
// Shared types and helpers for the sequential magnitude engine.
// Mode encodings, FSM states and the radicand width rule live here.
package hypot_pkg;

  typedef enum logic [1:0] {
    HYP = 2'b00,  // x^2 + y^2
    ID  = 2'b01,  // x
    GEO = 2'b10,  // x * y
    LEG = 2'b11   // |x^2 - y^2|
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    ITER = 2'b10,
    DONE = 2'b11
  } state_e;

  function automatic int rad_w(input int in_w);
    return 2 * in_w + 1;
  endfunction

endpackage

// File: rtl/isqrt_step.sv
// One restoring digit-by-digit square-root step: bring down the next radicand
// bit pair, try subtracting (4q+1), and shift the resulting root bit into q.
module isqrt_step #(
  parameter int RW = 9
) (
  input  logic [RW:0]   rem_acc,
  input  logic [RW-1:0] q,
  input  logic [1:0]    pair,
  output logic [RW:0]   rem_next,
  output logic [RW-1:0] q_next
);

  localparam int CW = RW + 3;

  logic [CW-1:0] cand;
  logic [CW-1:0] trial;
  logic [CW-1:0] diff;
  logic          take;

  assign cand  = {rem_acc, pair};
  assign trial = {1'b0, q, 2'b01};
  assign diff  = cand - trial;
  assign take  = (cand >= trial);

  // The partial remainder never exceeds 2*q_next, so RW+1 bits always hold it.
  always_comb begin
    rem_next = take ? (RW+1)'(diff) : (RW+1)'(cand);
    q_next   = (q << 1) | RW'(take);
  end

endmodule

// File: rtl/hypot_seq_core.sv
// Multi-cycle integer magnitude engine: forms a radicand from x/y/mode and
// extracts its square root one bit per cycle behind valid/ready handshakes.
module hypot_seq_core
  import hypot_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter bit ROUND = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] x,
  input  logic [IN_W-1:0] y,
  input  logic [1:0]      mode,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [IN_W:0]   root,
  output logic [IN_W+1:0] rem,
  output logic            exact
);

  localparam int RW    = IN_W + 1;
  localparam int REM_W = RW + 1;
  localparam int RAD_W = rad_w(IN_W);
  localparam int SR_W  = 2 * RW;
  localparam int SQ_W  = 2 * IN_W;
  localparam int CNT_W = $clog2(RW);

  state_e            state_reg;
  mode_e             mode_reg;
  logic [IN_W-1:0]   x_reg;
  logic [IN_W-1:0]   y_reg;
  logic [SR_W-1:0]   rad_reg;
  logic [REM_W-1:0]  rem_acc_reg;
  logic [RW-1:0]     q_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              out_valid_reg;
  logic [RW-1:0]     root_reg;
  logic [REM_W-1:0]  rem_reg;
  logic              exact_reg;

  logic [SQ_W-1:0]   xx;
  logic [SQ_W-1:0]   yy;
  logic [SQ_W-1:0]   xy;
  logic [RAD_W-1:0]  rad_calc;
  logic [REM_W-1:0]  step_rem;
  logic [RW-1:0]     step_q;

  assign xx = {{IN_W{1'b0}}, x_reg} * {{IN_W{1'b0}}, x_reg};
  assign yy = {{IN_W{1'b0}}, y_reg} * {{IN_W{1'b0}}, y_reg};
  assign xy = {{IN_W{1'b0}}, x_reg} * {{IN_W{1'b0}}, y_reg};

  // The difference mode always subtracts the smaller square from the larger.
  always_comb begin
    rad_calc = '0;
    case (mode_reg)
      HYP:     rad_calc = RAD_W'(xx) + RAD_W'(yy);
      ID:      rad_calc = RAD_W'(x_reg);
      GEO:     rad_calc = RAD_W'(xy);
      LEG:     rad_calc = (xx >= yy) ? RAD_W'(xx - yy) : RAD_W'(yy - xx);
      default: rad_calc = '0;
    endcase
  end

  isqrt_step #(
    .RW(RW)
  ) u_step (
    .rem_acc  (rem_acc_reg),
    .q        (q_reg),
    .pair     (rad_reg[SR_W-1 -: 2]),
    .rem_next (step_rem),
    .q_next   (step_q)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      mode_reg      <= HYP;
      x_reg         <= '0;
      y_reg         <= '0;
      rad_reg       <= '0;
      rem_acc_reg   <= '0;
      q_reg         <= '0;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
      root_reg      <= '0;
      rem_reg       <= '0;
      exact_reg     <= 1'b0;
    end else if (ena) begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            x_reg     <= x;
            y_reg     <= y;
            mode_reg  <= mode_e'(mode);
            state_reg <= LOAD;
          end
        end
        LOAD: begin
          rad_reg     <= SR_W'(rad_calc);
          cnt_reg     <= CNT_W'(RW - 1);
          rem_acc_reg <= '0;
          q_reg       <= '0;
          state_reg   <= ITER;
        end
        ITER: begin
          rad_reg     <= rad_reg << 2;
          rem_acc_reg <= step_rem;
          q_reg       <= step_q;
          if (cnt_reg == '0) begin
            // Rounding up is correct exactly when R - q^2 exceeds q.
            root_reg      <= (ROUND && (step_rem > REM_W'(step_q))) ? step_q + RW'(1) : step_q;
            rem_reg       <= step_rem;
            exact_reg     <= (step_rem == '0);
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE) && ena;
  assign out_valid = out_valid_reg;
  assign root      = root_reg;
  assign rem       = rem_reg;
  assign exact     = exact_reg;

endmodule

// File: tb/tb_hypot_seq_core.sv
// Directed bench for hypot_seq_core (IN_W=8) with a floor and a rounding
// instance sharing one stimulus stream.
module tb_hypot_seq_core;
  import hypot_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, ena, in_valid, out_ready;
  logic [7:0] x, y;
  logic [1:0] mode;
  logic       in_ready0, out_valid0, exact0;
  logic       in_ready1, out_valid1, exact1;
  logic [8:0] root0, root1;
  logic [9:0] rem0, rem1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hypot_seq_core #(.IN_W(8), .ROUND(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready0),
    .x(x), .y(y), .mode(mode), .out_valid(out_valid0), .out_ready(out_ready),
    .root(root0), .rem(rem0), .exact(exact0)
  );

  hypot_seq_core #(.IN_W(8), .ROUND(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ena(ena), .in_valid(in_valid), .in_ready(in_ready1),
    .x(x), .y(y), .mode(mode), .out_valid(out_valid1), .out_ready(out_ready),
    .root(root1), .rem(rem1), .exact(exact1)
  );

  // Present one op and return just after its accept edge; operands are then scrambled.
  task automatic accept_op(input logic [7:0] ax, input logic [7:0] ay, input logic [1:0] am);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready0 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    n_cmp++;
    if (!in_ready0) begin
      n_bad++;
      $display("FAIL accept_timeout in_ready got %0b want 1", in_ready0);
    end
    x = ax; y = ay; mode = am; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; x = 8'hA5; y = 8'h5A; mode = 2'b10;
  endtask

  // Count rising edges from the accept edge until out_valid is seen.
  task automatic wait_result(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid0 && lat < 60);
    n_cmp++;
    if (!out_valid0) begin
      n_bad++;
      $display("FAIL result_timeout out_valid got %0b want 1 after %0d edges", out_valid0, lat);
    end
  endtask

  task automatic take_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    x = '0; y = '0; mode = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({out_valid0, root0, rem0, exact0, in_ready0} !== {1'b0, 9'd0, 10'd0, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_state got ov=%0b root=%0d rem=%0d ex=%0b rdy=%0b want 0 0 0 0 1",
               out_valid0, root0, rem0, exact0, in_ready0);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    int lat;
    accept_op(8'd3, 8'd4, HYP);
    wait_result(lat);
    n_cmp++;
    if (lat !== 10 || out_valid1 !== 1'b1) begin
      n_bad++;
      $display("FAIL latency_34 got %0d edges (ov1=%0b) want 10 (1)", lat, out_valid1);
    end
    n_cmp++;
    if ({root0, rem0, exact0, root1} !== {9'd5, 10'd0, 1'b1, 9'd5}) begin
      n_bad++;
      $display("FAIL hyp_34 got root=%0d rem=%0d ex=%0b rootr=%0d want 5 0 1 5", root0, rem0, exact0, root1);
    end
    take_result();
  endtask

  task automatic test_vectors();
    int tx[14]  = '{7, 8, 10, 255, 3, 5, 4, 200, 255, 255, 255, 0, 0, 0};
    int ty[14]  = '{24, 6, 15, 255, 5, 3, 9, 0, 255, 0, 0, 0, 0, 0};
    int tm[14]  = '{0, 0, 0, 0, 3, 3, 2, 1, 2, 3, 1, 0, 1, 3};
    int er[14]  = '{25, 10, 18, 360, 4, 4, 6, 14, 255, 255, 15, 0, 0, 0};
    int em[14]  = '{0, 0, 1, 450, 0, 0, 0, 4, 0, 0, 30, 0, 0, 0};
    int ee[14]  = '{1, 1, 0, 0, 1, 1, 1, 0, 1, 1, 0, 1, 1, 1};
    int err[14] = '{25, 10, 18, 361, 4, 4, 6, 14, 255, 255, 16, 0, 0, 0};
    int lat;
    for (int i = 0; i < 14; i++) begin
      accept_op(8'(tx[i]), 8'(ty[i]), 2'(tm[i]));
      wait_result(lat);
      n_cmp++;
      if (root0 !== 9'(er[i]) || rem0 !== 10'(em[i]) || exact0 !== 1'(ee[i]) || root1 !== 9'(err[i])) begin
        n_bad++;
        $display("FAIL vec%0d (x=%0d y=%0d m=%0d) got root=%0d rem=%0d ex=%0b rootr=%0d want %0d %0d %0d %0d",
                 i, tx[i], ty[i], tm[i], root0, rem0, exact0, root1, er[i], em[i], ee[i], err[i]);
      end
      take_result();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    accept_op(8'd3, 8'd4, HYP);
    wait_result(lat);
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1; x = 8'd9; y = 8'd12; mode = HYP;
      @(negedge clk);
      n_cmp++;
      if ({out_valid0, root0, in_ready0} !== {1'b1, 9'd5, 1'b0}) begin
        n_bad++;
        $display("FAIL stall_c%0d got ov=%0b root=%0d rdy=%0b want 1 5 0", c, out_valid0, root0, in_ready0);
      end
    end
    in_valid = 1'b0;
    take_result();
    @(negedge clk);
    n_cmp++;
    if ({out_valid0, root0, in_ready0} !== {1'b0, 9'd5, 1'b1}) begin
      n_bad++;
      $display("FAIL after_handshake got ov=%0b root=%0d rdy=%0b want 0 5 1", out_valid0, root0, in_ready0);
    end
    accept_op(8'd8, 8'd6, HYP);
    wait_result(lat);
    n_cmp++;
    if (root0 !== 9'd10 || lat !== 10) begin
      n_bad++;
      $display("FAIL post_stall got root=%0d lat=%0d want 10 10", root0, lat);
    end
    take_result();
  endtask

  task automatic test_ena();
    int lat;
    // Idle with ena low: a held request must not be taken.
    @(negedge clk);
    ena = 1'b0; in_valid = 1'b1; x = 8'd7; y = 8'd24; mode = HYP;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (in_ready0 !== 1'b0 || out_valid0 !== 1'b0) begin
      n_bad++;
      $display("FAIL ena_idle got rdy=%0b ov=%0b want 0 0", in_ready0, out_valid0);
    end
    in_valid = 1'b0; ena = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready0 !== 1'b1) begin
      n_bad++;
      $display("FAIL ena_idle_resume got rdy=%0b want 1", in_ready0);
    end
    accept_op(8'd10, 8'd15, HYP);
    repeat (4) @(posedge clk);
    @(negedge clk);
    ena = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (out_valid0 !== 1'b0 || in_ready0 !== 1'b0) begin
      n_bad++;
      $display("FAIL ena_freeze got ov=%0b rdy=%0b want 0 0", out_valid0, in_ready0);
    end
    ena = 1'b1;
    wait_result(lat);
    n_cmp++;
    if (lat + 9 !== 15 || root0 !== 9'd18 || rem0 !== 10'd1 || exact0 !== 1'b0) begin
      n_bad++;
      $display("FAIL ena_stall got lat=%0d root=%0d rem=%0d ex=%0b want 15 18 1 0",
               lat + 9, root0, rem0, exact0);
    end
    take_result();
  endtask

  task automatic test_reset_mid();
    int lat;
    accept_op(8'd7, 8'd24, HYP);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++;
    if ({out_valid0, root0, in_ready0} !== {1'b0, 9'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL reset_mid got ov=%0b root=%0d rdy=%0b want 0 0 1", out_valid0, root0, in_ready0);
    end
    accept_op(8'd3, 8'd4, HYP);
    wait_result(lat);
    n_cmp++;
    if (root0 !== 9'd5 || lat !== 10) begin
      n_bad++;
      $display("FAIL reset_recover got root=%0d lat=%0d want 5 10", root0, lat);
    end
    take_result();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_vectors();
    test_backpressure();
    test_ena();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
